// File: rtl/dual_pueo_thresh_loader.sv
// Shadow threshold registers for PUEO channels A/B, streamed into the threshold
// DSP cascade last-beam-first, followed by a gap and a single update strobe.
module dual_pueo_thresh_loader #(
    parameter int unsigned                 NBEAMS       = 48,
    parameter int unsigned                 THRESH_BITS  = 18,
    parameter int unsigned                 UPDATE_DELAY = 1,
    parameter logic [THRESH_BITS-1:0]      INIT_THRESH  = 18'h3FFFF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [$clog2(NBEAMS)-1:0]      reg_addr_i,
    input  logic                           reg_chan_i,
    input  logic [THRESH_BITS-1:0]         reg_dat_i,
    input  logic                           reg_wr_i,
    input  logic                           apply_i,
    output logic [2*THRESH_BITS-1:0]       thresh_o,
    output logic [1:0]                     thresh_wr_o,
    output logic [1:0]                     thresh_update_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           wr_drop_o
);

    localparam int unsigned AW = $clog2(NBEAMS);
    localparam int unsigned TW = THRESH_BITS;
    localparam int unsigned GW = 3;

    typedef enum logic [1:0] {IDLE, STREAM, GAP, UPDATE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                pend_q, pend_d;
    logic [2*TW-1:0]     thr_q, thr_d;
    logic [1:0]          twr_q, twr_d;
    logic [1:0]          upd_q, upd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                drop_q, drop_d;

    logic [TW-1:0]       sh_a_q [NBEAMS];
    logic [TW-1:0]       sh_b_q [NBEAMS];

    logic                wr_ok_c;
    logic                load_c;
    logic [AW-1:0]       rd_idx_c;
    logic [TW-1:0]       rd_a_c, rd_b_c;

    assign wr_ok_c = reg_wr_i && !busy_q && (32'(reg_addr_i) < NBEAMS);

    // Shadow read with forwarding so a write in the apply cycle is streamed.
    always_comb begin
        rd_a_c = sh_a_q[rd_idx_c];
        rd_b_c = sh_b_q[rd_idx_c];
        if (wr_ok_c && (reg_addr_i == rd_idx_c)) begin
            if (reg_chan_i) rd_b_c = reg_dat_i;
            else            rd_a_c = reg_dat_i;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        pend_d   = pend_q;
        twr_d    = 2'b00;
        upd_d    = 2'b00;
        done_d   = 1'b0;
        drop_d   = reg_wr_i && !wr_ok_c;
        rd_idx_c = cnt_q;
        load_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (apply_i) begin
                    state_d  = STREAM;
                    cnt_d    = AW'(NBEAMS - 1);
                    rd_idx_c = AW'(NBEAMS - 1);
                    load_c   = 1'b1;
                    twr_d    = 2'b11;
                end
            end
            STREAM: begin
                if (apply_i) pend_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = GAP;
                    gap_d   = GW'(UPDATE_DELAY - 1);
                end else begin
                    cnt_d    = cnt_q - AW'(1);
                    rd_idx_c = cnt_q - AW'(1);
                    load_c   = 1'b1;
                    twr_d    = 2'b11;
                end
            end
            GAP: begin
                if (apply_i) pend_d = 1'b1;
                if (gap_q == '0) begin
                    state_d = UPDATE;
                    upd_d   = 2'b11;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            UPDATE: begin
                if (pend_q || apply_i) begin
                    state_d  = STREAM;
                    pend_d   = 1'b0;
                    cnt_d    = AW'(NBEAMS - 1);
                    rd_idx_c = AW'(NBEAMS - 1);
                    load_c   = 1'b1;
                    twr_d    = 2'b11;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        thr_d  = load_c ? {rd_b_c, rd_a_c} : thr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            pend_q  <= 1'b0;
            thr_q   <= '0;
            twr_q   <= 2'b00;
            upd_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < int'(NBEAMS); i++) begin
                sh_a_q[i] <= INIT_THRESH;
                sh_b_q[i] <= INIT_THRESH;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            thr_q   <= thr_d;
            twr_q   <= twr_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            if (wr_ok_c) begin
                if (reg_chan_i) sh_b_q[reg_addr_i] <= reg_dat_i;
                else            sh_a_q[reg_addr_i] <= reg_dat_i;
            end
        end
    end

    assign thresh_o        = thr_q;
    assign thresh_wr_o     = twr_q;
    assign thresh_update_o = upd_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign wr_drop_o       = drop_q;

endmodule

// File: tb/tb_dual_pueo_thresh_loader.sv
// Scoreboard bench: the driver schedules expected cascade traffic per cycle label
// from a sequence-level model; a negedge monitor pops and compares.
module tb_dual_pueo_thresh_loader;

    localparam int unsigned N  = 6;
    localparam int unsigned TW = 18;
    localparam int unsigned D  = 2;
    localparam int unsigned AW = $clog2(N);
    localparam logic [TW-1:0] INIT = 18'h3FFFF;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [AW-1:0]   reg_addr_i = '0;
    logic            reg_chan_i = 1'b0;
    logic [TW-1:0]   reg_dat_i = '0;
    logic            reg_wr_i = 1'b0;
    logic            apply_i = 1'b0;
    logic [2*TW-1:0] thresh_o;
    logic [1:0]      thresh_wr_o;
    logic [1:0]      thresh_update_o;
    logic            busy_o;
    logic            done_o;
    logic            wr_drop_o;

    dual_pueo_thresh_loader #(
        .NBEAMS(N), .THRESH_BITS(TW), .UPDATE_DELAY(D), .INIT_THRESH(INIT)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .reg_addr_i(reg_addr_i), .reg_chan_i(reg_chan_i),
        .reg_dat_i(reg_dat_i), .reg_wr_i(reg_wr_i), .apply_i(apply_i),
        .thresh_o(thresh_o), .thresh_wr_o(thresh_wr_o), .thresh_update_o(thresh_update_o),
        .busy_o(busy_o), .done_o(done_o), .wr_drop_o(wr_drop_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              lbl;
        logic [1:0]      wr;
        logic [1:0]      upd;
        logic [2*TW-1:0] thr;
    } ev_t;

    ev_t         q_stream[$];
    int          q_drop[$];
    int          q_rst[$];
    bit          exp_busy[int];
    logic [TW-1:0] sh_a[N];
    logic [TW-1:0] sh_b[N];
    int          busy_start = -1;
    int          busy_end   = -1;
    bit          pending    = 1'b0;
    bit          fin        = 1'b0;
    int          checks     = 0;
    int          errors     = 0;

    // A sequence accepted at edge k: beams N-1..0, D gap cycles, then update.
    task automatic start_seq(input int k);
        logic [2*TW-1:0] last;
        last = '0;
        for (int i = 0; i < int'(N); i++) begin
            last = {sh_b[N-1-i], sh_a[N-1-i]};
            q_stream.push_back('{k + i, 2'b11, 2'b00, last});
        end
        for (int g = 0; g < int'(D); g++)
            q_stream.push_back('{k + int'(N) + g, 2'b00, 2'b00, last});
        q_stream.push_back('{k + int'(N) + int'(D), 2'b00, 2'b11, last});
        for (int t = k; t <= k + int'(N) + int'(D); t++) exp_busy[t] = 1'b1;
        busy_start = k;
        busy_end   = k + int'(N) + int'(D);
    endtask

    task automatic drive(input bit rst, input bit wr, input bit chan, input int addr,
                         input logic [TW-1:0] dat, input bit apply);
        int e;
        bit busy_now;
        @(negedge clk);
        e = cyc + 1;
        rst_i      = rst;
        reg_wr_i   = wr;
        reg_chan_i = chan;
        reg_addr_i = AW'(addr);
        reg_dat_i  = dat;
        apply_i    = apply;
        if (rst) begin
            while (q_stream.size() > 0 && q_stream[$].lbl >= e) void'(q_stream.pop_back());
            for (int t = e; t <= busy_end; t++) exp_busy.delete(t);
            q_rst.push_back(e);
            for (int i = 0; i < int'(N); i++) begin
                sh_a[i] = INIT;
                sh_b[i] = INIT;
            end
            busy_start = -1;
            busy_end   = -1;
            pending    = 1'b0;
        end else begin
            busy_now = (cyc >= busy_start) && (cyc <= busy_end);
            if (wr) begin
                if (busy_now || addr >= int'(N)) q_drop.push_back(e);
                else if (chan) sh_b[addr] = dat;
                else           sh_a[addr] = dat;
            end
            if (apply) begin
                if (!busy_now) start_seq(e);
                else           pending = 1'b1;
            end
            if (busy_now && cyc == busy_end && pending) begin
                pending = 1'b0;
                start_seq(e);
            end
        end
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic wr_reg(input bit chan, input int addr, input logic [TW-1:0] dat, input bit apply);
        drive(1'b0, 1'b1, chan, addr, dat, apply);
    endtask

    // Monitor: compares DUT outputs against the scheduled expectations.
    always @(negedge clk) begin
        ev_t ev;
        bit  eb;
        if (cyc >= 1 && !fin) begin
            eb = exp_busy.exists(cyc);
            checks++;
            if (busy_o !== eb) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, eb);
            end
            if (q_rst.size() > 0 && q_rst[0] == cyc) begin
                void'(q_rst.pop_front());
                checks++;
                if (thresh_o !== '0 || thresh_wr_o !== 2'b00 || thresh_update_o !== 2'b00 ||
                    done_o !== 1'b0 || wr_drop_o !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_outs cyc=%0d thr=%h wr=%b upd=%b done=%b drop=%b exp all zero",
                             cyc, thresh_o, thresh_wr_o, thresh_update_o, done_o, wr_drop_o);
                end
            end
            if (q_stream.size() > 0 && q_stream[0].lbl == cyc) begin
                ev = q_stream.pop_front();
                checks++;
                if (thresh_wr_o !== ev.wr || thresh_update_o !== ev.upd ||
                    done_o !== (ev.upd != 2'b00) || thresh_o !== ev.thr) begin
                    errors++;
                    $display("FAIL stream cyc=%0d got wr=%b upd=%b done=%b thr=%h exp wr=%b upd=%b thr=%h",
                             cyc, thresh_wr_o, thresh_update_o, done_o, thresh_o, ev.wr, ev.upd, ev.thr);
                end
            end else if (thresh_wr_o !== 2'b00 || thresh_update_o !== 2'b00 || done_o !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_stream cyc=%0d got wr=%b upd=%b done=%b exp idle",
                         cyc, thresh_wr_o, thresh_update_o, done_o);
            end
            if (wr_drop_o === 1'b1) begin
                checks++;
                if (q_drop.size() > 0 && q_drop[0] == cyc) begin
                    void'(q_drop.pop_front());
                end else begin
                    errors++;
                    $display("FAIL wr_drop cyc=%0d got=1 exp=0", cyc);
                end
            end else if (q_drop.size() > 0 && q_drop[0] <= cyc) begin
                void'(q_drop.pop_front());
                checks++;
                errors++;
                $display("FAIL wr_drop cyc=%0d got=%b exp=1", cyc, wr_drop_o);
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(N); i++) begin
            sh_a[i] = INIT;
            sh_b[i] = INIT;
        end
        drive(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
        nop(2);

        // Apply with no writes: all INIT values.
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        nop(N + D + 3);

        // Top-beam writes, then a write coincident with apply.
        wr_reg(1'b0, N - 1, 18'd10, 1'b0);
        wr_reg(1'b1, N - 1, 18'd20, 1'b0);
        wr_reg(1'b1, 0, 18'd200, 1'b0);
        wr_reg(1'b0, 0, 18'd200, 1'b1);
        nop(2);
        // Write while busy is dropped.
        wr_reg(1'b0, 3, 18'h12345, 1'b0);
        nop(N + D + 3);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        nop(N + D + 3);

        // Out-of-range address in IDLE is dropped.
        wr_reg(1'b1, 7, 18'h00ABC, 1'b0);
        wr_reg(1'b0, N, 18'h00DEF, 1'b0);
        nop(2);

        // Three applies during STREAM coalesce into one rerun.
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        nop(1);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        nop(2 * (N + D + 1) + 3);

        // Apply exactly in the UPDATE cycle: rerun follows immediately.
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        nop(N + D - 1);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        nop(2 * (N + D + 1) + 3);

        // Reset mid-STREAM, then reapply shows INIT values.
        wr_reg(1'b0, 2, 18'h00055, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        nop(2);
        drive(1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
        nop(3);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        nop(N + D + 3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  TW'($urandom), ($urandom_range(0, 14) == 0));
        end
        nop(3 * (N + D + 1) + 5);

        @(negedge clk);
        fin = 1'b1;
        checks++;
        if (q_stream.size() != 0 || q_drop.size() != 0 || q_rst.size() != 0) begin
            errors++;
            $display("FAIL drain got stream=%0d drop=%0d rst=%0d pending exp 0",
                     q_stream.size(), q_drop.size(), q_rst.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
